// File: rtl/scroll_pkg.sv
// Shared constants for the scrolling test-pattern engine.
// Mode encodings and default widths.
package scroll_pkg;

  localparam int CW_DEF      = 10;
  localparam int SPEED_W_DEF = 4;

  typedef enum logic [1:0] {
    MODE_STRIPES = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_DIAG    = 2'd2,
    MODE_BARS    = 2'd3
  } mode_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers a sync line and flags entry into its asserted level.
// Register resets to the idle level so no edge fires out of reset.
module sync_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic sig_q,
  output logic tick
);

  localparam logic IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

  // Previous-cycle copy of the sync line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= IDLE;
    else        sig_q <= sig;
  end

  assign tick = (sig != IDLE) && (sig_q == IDLE);

endmodule

// File: rtl/scroll_pattern_engine.sv
// Scrolling colour-pattern generator, one offset step per frame.
// Optional: SCROLL_AUTO_CYCLE_EN rotates the mode every AUTO_FRAMES frames.
module scroll_pattern_engine
  import scroll_pkg::*;
#(
  parameter int CW               = CW_DEF,
  parameter int SPEED_W          = SPEED_W_DEF,
  parameter int VSYNC_ACTIVE_LOW = 1,
  parameter int AUTO_FRAMES      = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               active_in,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  input  logic [1:0]         mode_sel,
  input  logic [SPEED_W-1:0] speed,
  input  logic               dir,
  input  logic               pause,
  output logic [1:0]         r,
  output logic [1:0]         g,
  output logic [1:0]         b,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               frame_tick,
  output logic [1:0]         mode_out
);

  localparam bit    ALOW = (VSYNC_ACTIVE_LOW != 0);
  localparam logic  IDLE = ALOW ? 1'b1 : 1'b0;

  if (CW < 10) begin : g_bad_cw
    $error("CW must be at least 10");
  end
  if (AUTO_FRAMES < 1) begin : g_bad_af
    $error("AUTO_FRAMES must be at least 1");
  end

  logic          tick;
  logic [CW-1:0] offset;
  mode_e         mode;
  logic [9:0]    mx;
  logic [9:0]    d;
  logic [5:0]    rgb_n;

  sync_edge_detect #(
    .ACTIVE_LOW(ALOW)
  ) u_vs_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (vsync_in),
    .sig_q(vsync_out),
    .tick (tick)
  );

  assign mode_out = mode;
  assign mx = pix_x + offset[9:0];
  assign d  = mx + pix_y;

  // Pixel colour for the current mode and offset
  always_comb begin
    rgb_n = '0;
    unique case (1'b1)
      (mode == MODE_STRIPES):
        rgb_n = {mx[5], pix_y[2], mx[6], pix_y[2],
                 mx[7], pix_y[5]};
      (mode == MODE_CHECKER):
        rgb_n = {6{mx[5] ^ pix_y[5]}};
      (mode == MODE_DIAG):
        rgb_n = {d[6:5], d[7:6], d[8:7]};
      (mode == MODE_BARS):
        rgb_n = {mx[9:8], pix_y[8:7], offset[7:6]};
    endcase
    if (!active_in) rgb_n = '0;
  end

  // Colour and hsync pipeline, one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r, g, b} <= '0;
      hsync_out <= IDLE;
    end else begin
      {r, g, b} <= rgb_n;
      hsync_out <= hsync_in;
    end
  end

  // Per-frame offset step and tick pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick;
      if (tick && !pause) begin
        if (dir) offset <= offset - CW'(speed);
        else     offset <= offset + CW'(speed);
      end
    end
  end

`ifdef SCROLL_AUTO_CYCLE_EN
  localparam int AW = $clog2(AUTO_FRAMES + 1);
  logic [AW-1:0] frame_cnt;

  // Mode rotates after AUTO_FRAMES ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      mode      <= MODE_STRIPES;
    end else if (tick) begin
      if (frame_cnt == AW'(AUTO_FRAMES - 1)) begin
        frame_cnt <= '0;
        mode      <= mode_e'(mode + 2'd1);
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  // Mode follows mode_sel, latched once per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    mode <= MODE_STRIPES;
    else if (tick) mode <= mode_e'(mode_sel);
  end
`endif

endmodule

// File: tb/tb_scroll_pattern_engine.sv
// Scoreboard bench for scroll_pattern_engine (default build).
// Reference model computes colours from the pattern rules directly.
module tb_scroll_pattern_engine;

  localparam int VAL = 1;

  typedef struct {
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
    logic       ft;
    logic [1:0] mode;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hsync_in, vsync_in, active_in;
  logic [9:0] pix_x, pix_y;
  logic [1:0] mode_sel;
  logic [3:0] speed;
  logic       dir, pause;
  logic [1:0] r, g, b;
  logic       hsync_out, vsync_out, frame_tick;
  logic [1:0] mode_out;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   ft_cnt = 0;

  int   m_off, m_mode;
  bit   m_prev;

  scroll_pattern_engine #(
    .CW(10), .SPEED_W(4),
    .VSYNC_ACTIVE_LOW(VAL), .AUTO_FRAMES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .active_in(active_in),
    .pix_x(pix_x), .pix_y(pix_y),
    .mode_sel(mode_sel), .speed(speed),
    .dir(dir), .pause(pause),
    .r(r), .g(g), .b(b),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_tick(frame_tick), .mode_out(mode_out)
  );

  always #5 clk = ~clk;

  function automatic int bt(int v, int n);
    return (v >> n) & 1;
  endfunction

  function automatic logic [5:0] colour(
    int m, int off, int x, int y, bit act);
    int mx, d, rr, gg, bb, c;
    logic [5:0] res;
    mx = (x + off) % 1024;
    d  = (mx + y) % 1024;
    rr = 0; gg = 0; bb = 0;
    case (m)
      0: begin
        rr = bt(mx, 5) * 2 + bt(y, 2);
        gg = bt(mx, 6) * 2 + bt(y, 2);
        bb = bt(mx, 7) * 2 + bt(y, 5);
      end
      1: begin
        c = bt(mx, 5) ^ bt(y, 5);
        rr = 3 * c; gg = rr; bb = rr;
      end
      2: begin
        rr = (d >> 5) % 4;
        gg = (d >> 6) % 4;
        bb = (d >> 7) % 4;
      end
      default: begin
        rr = mx / 256;
        gg = (y >> 7) % 4;
        bb = (off / 64) % 4;
      end
    endcase
    res = {rr[1:0], gg[1:0], bb[1:0]};
    if (!act) res = '0;
    return res;
  endfunction

  function automatic logic lvl(bit asrt);
    return (VAL != 0) ? ~asrt : asrt;
  endfunction

  task automatic chk(string nm, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, req);
    end
  endtask

  task automatic step(bit vs_a, bit hs_a, bit act,
                      int x, int y, int ms, int sp,
                      bit dr, bit pa);
    exp_t e;
    bit   tk;
    @(negedge clk);
    vsync_in  = lvl(vs_a);
    hsync_in  = lvl(hs_a);
    active_in = act;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    mode_sel  = 2'(ms);
    speed     = 4'(sp);
    dir       = dr;
    pause     = pa;
    e.rgb = colour(m_mode, m_off, x, y, act);
    e.hs  = hsync_in;
    e.vs  = vsync_in;
    tk = vs_a && !m_prev;
    m_prev = vs_a;
    if (tk) begin
      if (!pa) begin
        if (dr) m_off = (m_off - sp + 1024) % 1024;
        else    m_off = (m_off + sp) % 1024;
      end
      m_mode = ms;
    end
    e.ft   = tk;
    e.mode = 2'(m_mode);
    q.push_back(e);
  endtask

  task automatic frame(int ms, int sp, bit dr, bit pa);
    for (int i = 0; i < 6; i++)
      step(i < 2, i == 3, 1'b1,
           $urandom_range(1023), $urandom_range(1023),
           ms, sp, dr, pa);
  endtask

  task automatic idle_inputs();
    vsync_in = lvl(1'b0); hsync_in = lvl(1'b0);
    active_in = 0; pix_x = 0; pix_y = 0;
    mode_sel = 0; speed = 0; dir = 0; pause = 0;
  endtask

  task automatic check_reset(string nm);
    chk({nm, "_rgb"}, {r, g, b}, 0);
    chk({nm, "_ft"}, frame_tick, 0);
    chk({nm, "_mode"}, mode_out, 0);
    chk({nm, "_hs"}, hsync_out, lvl(1'b0));
    chk({nm, "_vs"}, vsync_out, lvl(1'b0));
  endtask

  task automatic do_reset(string nm);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset(nm);
    m_off = 0; m_mode = 0; m_prev = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic probe(string nm, int req);
    @(posedge clk);
    #1;
    chk(nm, {r, g, b}, req);
  endtask

  // Monitor: compare DUT outputs against queued expectations
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (frame_tick) ft_cnt++;
        if ({r, g, b} != e.rgb || hsync_out != e.hs ||
            vsync_out != e.vs || frame_tick != e.ft ||
            mode_out != e.mode) begin
          fails++;
          $display("FAIL sb t=%0t: rgb/hs/vs/ft/mode got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                   $time, {r, g, b}, hsync_out, vsync_out,
                   frame_tick, mode_out, e.rgb, e.hs,
                   e.vs, e.ft, e.mode);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int len, vlen;
    rst_n = 1'b0;
    m_off = 0; m_mode = 0; m_prev = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    // Five frames at speed 3 forward -> offset 15
    ft_cnt = 0;
    for (int f = 0; f < 5; f++) frame(0, 3, 0, 0);
    step(0, 0, 1, 17, 0, 0, 0, 0, 0);
    probe("off15_x17", 6'b100000);
    chk("five_ticks", ft_cnt, 5);

    // Mid-frame reset, then wrap below zero
    step(1, 0, 1, 5, 5, 0, 0, 0, 0);
    do_reset("midreset");
    frame(0, 1, 1, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    probe("wrap_1023", 6'b101010);

    // Checker at offset 0
    do_reset("reset2");
    frame(1, 0, 0, 0);
    step(0, 0, 1, 32, 0, 1, 0, 0, 0);
    probe("checker_on", 6'b111111);
    step(0, 0, 0, 32, 0, 1, 0, 0, 0);
    probe("checker_blank", 6'b000000);

    // Mode change mid-frame takes effect at tick
    step(0, 0, 1, 9, 9, 2, 7, 0, 1);
    #2;
    chk("mode_hold", mode_out, 1);
    frame(2, 7, 0, 1);
    chk("mode_new", mode_out, 2);
    step(0, 0, 1, 32, 0, 2, 0, 0, 0);
    probe("paused_off0", 6'b010000);

    // Randomised frames
    for (int f = 0; f < 150; f++) begin
      len  = $urandom_range(6, 20);
      vlen = $urandom_range(1, 3);
      for (int i = 0; i < len; i++)
        step(i < vlen, $urandom_range(1), $urandom_range(1),
             $urandom_range(1023), $urandom_range(1023),
             $urandom_range(3), $urandom_range(15),
             $urandom_range(1), $urandom_range(3) == 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
